// File: rtl/rf_ctrl_pkg.sv
// RF control shared definitions: mode encodings, IO control
// register address, helpers and the mode sequencer state set.
package rf_ctrl_pkg;

  localparam logic [2:0] RF_LOW_POWER = 3'b000;
  localparam logic [2:0] RF_BYPASS    = 3'b001;
  localparam logic [2:0] RF_RX_LPF    = 3'b010;
  localparam logic [2:0] RF_RX_HPF    = 3'b011;
  localparam logic [2:0] RF_TX_LPF    = 3'b100;
  localparam logic [2:0] RF_TX_HPF    = 3'b101;

  localparam logic [4:0] IOC_MODE        = 5'b00001;
  localparam logic [1:0] DEBUG_MODE_NONE = 2'b00;

  typedef enum logic [2:0] {
    ST_INIT_WR,
    ST_IDLE,
    ST_BREAK_WR,
    ST_GUARD,
    ST_MAKE_WR,
    ST_SETTLE,
    ST_DONE
  } seq_state_e;

  function automatic logic is_tx(input logic [2:0] m);
    return m[2:1] == 2'b10;
  endfunction

  function automatic logic is_legal(input logic [2:0] m);
    return m <= RF_TX_HPF;
  endfunction

endpackage

// File: rtl/rf_mode_sequencer_if.sv
// Host request handshake plus IO control write port
// of the RF mode sequencer.
interface rf_mode_sequencer_if;
  logic       req_valid;
  logic [2:0] req_mode;
  logic       req_ready;
  logic       cs;
  logic       load_cmd;
  logic [4:0] ioc;
  logic [7:0] data;

  modport master (
    output req_valid,
    output req_mode,
    input  req_ready,
    input  cs,
    input  load_cmd,
    input  ioc,
    input  data
  );

  modport slave (
    input  req_valid,
    input  req_mode,
    output req_ready,
    output cs,
    output load_cmd,
    output ioc,
    output data
  );
endinterface

// File: rtl/rf_seq_timer.sv
// Loadable down-counter with zero flag, shared by the
// guard and settle phases of the mode sequencer.
module rf_seq_timer #(
  parameter int W = 7
) (
  input  logic         i_sys_clk,
  input  logic         i_rst_b,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rf_mode_sequencer.sv
// Break-before-make RF mode sequencer: low-power write, guard,
// target write, settle, then a done pulse.
module rf_mode_sequencer
  import rf_ctrl_pkg::*;
#(
  parameter int GUARD_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic                i_sys_clk,
  input  logic                i_rst_b,
  rf_mode_sequencer_if.slave  bus,
  input  logic                i_tx_inhibit,
  output logic [2:0]          o_cur_mode,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam int MAX_C =
    (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);

  seq_state_e state;
  logic [2:0] target;
  logic [2:0] cur_mode;
  logic       abort;
  logic       cs_q;
  logic       ready_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;
  logic [4:0] ioc_q;
  logic [7:0] data_q;

  logic             t_load;
  logic             t_dec;
  logic [CNT_W-1:0] t_val;
  logic             t_zero;

  logic auto_sd;
  logic tx_block;
  logic req_bad;

  assign auto_sd  = i_tx_inhibit && is_tx(cur_mode);
  assign tx_block = is_tx(target) && i_tx_inhibit;
  assign req_bad  = !is_legal(bus.req_mode) ||
                    (is_tx(bus.req_mode) && i_tx_inhibit);

  // Settle after INIT_WR also spans the write cycle itself,
  // hence the full count there and count-1 elsewhere.
  always_comb begin
    t_load = 1'b0;
    t_dec  = 1'b0;
    t_val  = '0;
    unique case (state)
      ST_INIT_WR: begin
        t_load = 1'b1;
        t_val  = CNT_W'(SETTLE_CYCLES);
      end
      ST_BREAK_WR: begin
        t_load = 1'b1;
        if (target == RF_LOW_POWER)
          t_val = CNT_W'(SETTLE_CYCLES - 1);
        else
          t_val = CNT_W'(GUARD_CYCLES - 1);
      end
      ST_GUARD: begin
        if (tx_block) begin
          t_load = 1'b1;
          t_val  = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_MAKE_WR: begin
        t_load = 1'b1;
        t_val  = CNT_W'(SETTLE_CYCLES - 1);
      end
      ST_SETTLE: t_dec = 1'b1;
      default: ;
    endcase
  end

  rf_seq_timer #(.W(CNT_W)) u_timer (
    .i_sys_clk (i_sys_clk),
    .i_rst_b   (i_rst_b),
    .load      (t_load),
    .load_val  (t_val),
    .dec       (t_dec),
    .zero      (t_zero)
  );

  // Outputs are registered against the next state so the strobe
  // lines up with the write state it belongs to.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state    <= ST_INIT_WR;
      target   <= RF_LOW_POWER;
      cur_mode <= RF_LOW_POWER;
      abort    <= 1'b0;
      cs_q     <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ioc_q    <= IOC_MODE;
      data_q   <= 8'h00;
    end else begin
      cs_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ioc_q   <= IOC_MODE;
      unique case (state)
        ST_INIT_WR: begin
          cs_q     <= 1'b1;
          data_q   <= {3'b000, RF_LOW_POWER, DEBUG_MODE_NONE};
          cur_mode <= RF_LOW_POWER;
          target   <= RF_LOW_POWER;
          abort    <= 1'b0;
          state    <= ST_SETTLE;
        end
        ST_IDLE: begin
          if (auto_sd) begin
            target   <= RF_LOW_POWER;
            abort    <= 1'b0;
            cs_q     <= 1'b1;
            data_q   <= {3'b000, RF_LOW_POWER, DEBUG_MODE_NONE};
            cur_mode <= RF_LOW_POWER;
            state    <= ST_BREAK_WR;
          end else if (bus.req_valid && ready_q) begin
            target <= bus.req_mode;
            abort  <= 1'b0;
            if (req_bad) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
              state  <= ST_DONE;
            end else if (bus.req_mode == cur_mode) begin
              done_q <= 1'b1;
              state  <= ST_DONE;
            end else begin
              cs_q     <= 1'b1;
              data_q   <= {3'b000, RF_LOW_POWER, DEBUG_MODE_NONE};
              cur_mode <= RF_LOW_POWER;
              state    <= ST_BREAK_WR;
            end
          end else begin
            busy_q  <= 1'b0;
            ready_q <= !auto_sd;
          end
        end
        ST_BREAK_WR: begin
          if (target == RF_LOW_POWER)
            state <= ST_SETTLE;
          else
            state <= ST_GUARD;
        end
        ST_GUARD: begin
          if (tx_block) begin
            abort <= 1'b1;
            state <= ST_SETTLE;
          end else if (t_zero) begin
            cs_q     <= 1'b1;
            data_q   <= {3'b000, target, DEBUG_MODE_NONE};
            cur_mode <= target;
            state    <= ST_MAKE_WR;
          end
        end
        ST_MAKE_WR: state <= ST_SETTLE;
        ST_SETTLE: begin
          if (t_zero) begin
            done_q <= 1'b1;
            err_q  <= abort;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          ready_q <= !auto_sd;
          state   <= ST_IDLE;
        end
        default: state <= ST_INIT_WR;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.cs        = cs_q;
  assign bus.load_cmd  = cs_q;
  assign bus.ioc       = ioc_q;
  assign bus.data      = data_q;
  assign o_cur_mode    = cur_mode;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err         = err_q;

endmodule
